syn_current_gen: RTL and testbench
==================================

Name: syn_current_gen

Overview:
- Synapse front-end that produces the signed 8-bit input current consumed by a LIF neuron.
- Accepts a frame of W_NUM presynaptic spike bits through a valid/ready handshake.
- Accumulates the signed weights of the active inputs serially, one input per cycle, then updates a leaky synaptic current with that sum.
- Presents the current on ir as a held level, with a one-cycle out_valid strobe on each update.

Parameters:
- W_WID, 8, signed weight width in bits (2..16).
- W_NUM, 4, number of presynaptic inputs and weight entries (>=1).
- TAU_S, 2, synaptic decay shift; each update subtracts i_syn>>>TAU_S.
- AW, $clog2(W_NUM) (min 1), weight address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_we  in  1  weight write enable
- w_addr  in  AW  weight write index
- w_data  in  W_WID  signed weight value
- in_valid  in  1  spike frame valid
- in_ready  out  1  block can accept a frame
- in_spikes  in  W_NUM  spike frame; bit k gates weight k
- out_valid  out  1  one-cycle strobe: ir updated this cycle
- ir  out  8  signed synaptic current (registered)

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - all weights 0, i_syn 0, ir 0, out_valid 0.
  - State returns to IDLE; in_ready is 1 once reset is released.
  - An in-flight frame is discarded.
- States: IDLE, ACCUM, UPDATE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_spikes into a frame register, clear the accumulator and index k=0, go to ACCUM.
  - in_spikes is sampled only on that edge; later changes are ignored.
- ACCUM:
  - in_ready=0.
  - Each cycle: if frame bit k=1, acc += sign-extended weight[k]; then k++.
  - After k=W_NUM-1 is processed, go to UPDATE. ACCUM lasts exactly W_NUM cycles.
- UPDATE:
  - i_syn_next = i_syn - (i_syn>>>TAU_S) + acc, computed at full width.
  - Saturate the result to [-128,127]; the saturated value is written to both i_syn and ir.
  - out_valid=1 for this edge only; go to IDLE.
- Latency: the accept edge is cycle 0; ir and out_valid update at the edge ending cycle W_NUM+1. The next frame can be accepted on cycle W_NUM+2.
- Throughput: one frame per W_NUM+2 cycles.
- Arithmetic widths:
  - acc is W_WID+AW+1 bits signed and cannot overflow.
  - The UPDATE sum is computed at max(acc width, 8)+2 bits before saturation.
  - >>> is an arithmetic shift. A negative i_syn decays toward 0; i_syn=-1 with TAU_S=1 gives 0 when acc=0.
- Weight writes:
  - Accepted in any state; a write takes effect at the next edge.
  - If w_addr equals the index being read in ACCUM on the same cycle, the old weight is used.
  - A write to an index not yet reached in the current frame is used by that frame.
  - w_addr >= W_NUM: the write is ignored.
- ir holds its value between updates.
- All-zero frame: the full ACCUM/UPDATE sequence still runs and i_syn decays.
- in_valid high in ACCUM/UPDATE: the frame is not accepted (in_ready=0); the source must hold it.

Test Plan:
- Reset, then W_NUM=4, TAU_S=1, weights {10,-20,30,40}, frame 4'b1011.
  - Required: out_valid exactly 5 cycles after accept, ir=30.
  - in_ready low for 5 cycles after accept, high on the next cycle.
- Same weights, i_syn=30, then frames 4'b0000 three times.
  - Required: ir sequence 15, 8, 4. Per update with TAU_S=1: 30-(30>>>1)=15, 15-(15>>>1)=15-7=8, 8-(8>>>1)=4.
- Saturation, weights all 127, frame 4'b1111 → ir=127.
- Saturation, weights all -128, frame 4'b1111 → ir=-128.
- Negative decay with TAU_S=1: weights {-1,0,0,0}, frame 4'b0001 → ir=-1; then frame 4'b0000 → ir=0.
- Same-cycle write/read collision:
  - During ACCUM at k=2, write w_addr=2 w_data=100 while the frame uses bit 2; the old weight 30 is used.
  - In the same frame, write w_addr=3=5 at k=1; the new weight 5 is used.
  - Required: ir reflects 30 for index 2 and 5 for index 3.
- Reset mid-ACCUM (rst_n low at k=2):
  - Required: ir=0 and out_valid=0 immediately; in_ready=1 after release.
  - A new frame 4'b0001 with weights rewritten to 7 yields ir=7 and no stale contribution.

Source files
------------

// File: rtl/syn_current_gen.sv
// syn_current_gen: synapse front-end for a LIF neuron.
// Takes a spike frame, sums the active signed weights one input per cycle,
// then applies a leaky update to the synaptic current. The saturated result
// is held on ir, and out_valid pulses for one cycle on each update.
module syn_current_gen #(
  parameter int W_WID = 8,
  parameter int W_NUM = 4,
  parameter int TAU_S = 2,
  parameter int AW    = (W_NUM > 1) ? $clog2(W_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic [W_WID-1:0]        w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_NUM-1:0]        in_spikes,
  output logic                    out_valid,
  output logic signed [7:0]       ir
);

  // Accumulator wide enough for W_NUM weights of either sign.
  localparam int ACW = W_WID + AW + 1;
  // Update sum width: room for i_syn, its decay term and acc without wrap.
  localparam int SW  = ((ACW > 8) ? ACW : 8) + 2;
  localparam logic [AW-1:0] K_LAST = AW'(W_NUM - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'(127);
  localparam logic signed [SW-1:0] SAT_MIN = -SW'(128);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W_NUM-1:0]        frame_q, frame_d;
  logic signed [ACW-1:0]   acc_q, acc_d;
  logic [AW-1:0]           k_q, k_d;
  logic signed [7:0]       isyn_q, isyn_d;
  logic signed [7:0]       ir_q, ir_d;
  logic                    out_valid_q, out_valid_d;

  // Weight table, one register per entry so every entry can be reset.
  logic signed [W_WID-1:0] w_mem [W_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < W_NUM; gi++) begin : g_weight
      logic signed [W_WID-1:0] wr_q, wr_d;

      // Next value of this weight: replaced only by a write addressed to it.
      always_comb begin
        wr_d = wr_q;
        if (w_we && (w_addr == AW'(gi))) begin
          wr_d = w_data;
        end
      end

      // Weight register; a write lands at the edge, so a same-cycle read sees the old value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_q <= '0;
        end else begin
          wr_q <= wr_d;
        end
      end

      assign w_mem[gi] = wr_q;
    end
  endgenerate

  // Select the weight and frame bit for the input currently being accumulated.
  logic signed [W_WID-1:0] w_sel;
  logic                    bit_sel;

  always_comb begin
    w_sel   = '0;
    bit_sel = 1'b0;
    for (int i = 0; i < W_NUM; i++) begin
      if (k_q == AW'(i)) begin
        w_sel   = w_mem[i];
        bit_sel = frame_q[i];
      end
    end
  end

  // Leaky update arithmetic, all at SW bits, followed by saturation to 8 bits.
  logic signed [ACW-1:0] w_ext;
  logic signed [SW-1:0]  isyn_ext;
  logic signed [SW-1:0]  decay;
  logic signed [SW-1:0]  acc_ext;
  logic signed [SW-1:0]  sum_full;
  logic signed [7:0]     sat_val;

  always_comb begin
    w_ext    = {{(ACW - W_WID){w_sel[W_WID-1]}}, w_sel};
    isyn_ext = {{(SW - 8){isyn_q[7]}}, isyn_q};
    decay    = isyn_ext >>> TAU_S;
    acc_ext  = {{(SW - ACW){acc_q[ACW-1]}}, acc_q};
    sum_full = isyn_ext - decay + acc_ext;
    if (sum_full > SAT_MAX) begin
      sat_val = 8'sd127;
    end else if (sum_full < SAT_MIN) begin
      sat_val = -8'sd128;
    end else begin
      sat_val = sum_full[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, walk W_NUM inputs, one update cycle, back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_ACCUM;
      S_ACCUM:  if (k_q == K_LAST) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: only the idle state accepts a frame.
  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  // Datapath next values: frame capture, serial accumulation, saturated update.
  always_comb begin
    frame_d     = frame_q;
    acc_d       = acc_q;
    k_d         = k_q;
    isyn_d      = isyn_q;
    ir_d        = ir_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          frame_d = in_spikes;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      S_ACCUM: begin
        if (bit_sel) begin
          acc_d = acc_q + w_ext;
        end
        k_d = k_q + AW'(1);
      end
      S_UPDATE: begin
        isyn_d      = sat_val;
        ir_d        = sat_val;
        out_valid_d = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      isyn_q      <= '0;
      ir_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      isyn_q      <= isyn_d;
      ir_q        <= ir_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ir        = ir_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_syn_current_gen.sv
// Testbench for syn_current_gen: table-driven vectors, directed multi-cycle
// corner cases, and randomized frames against a behavioural model.
module tb_syn_current_gen;

  localparam int W_WID = 8;
  localparam int W_NUM = 4;
  localparam int TAU_S = 1;
  localparam int AW    = 2;
  localparam int LAT   = W_NUM + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 w_we = 1'b0;
  logic [AW-1:0]        w_addr = '0;
  logic [W_WID-1:0]     w_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W_NUM-1:0]     in_spikes = '0;
  logic                 out_valid;
  logic signed [7:0]    ir;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: plain integers.
  int m_w [W_NUM];
  int m_isyn;

  syn_current_gen #(
    .W_WID(W_WID), .W_NUM(W_NUM), .TAU_S(TAU_S), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .out_valid(out_valid), .ir(ir)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  // Floor division by 2^s, i.e. rounding toward minus infinity.
  function automatic int floor_div_pow2(input int x, input int s);
    int d;
    d = 1 << s;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int sat8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic model_frame(input logic [W_NUM-1:0] sp, output int res);
    int acc;
    acc = 0;
    for (int k = 0; k < W_NUM; k++) if (sp[k]) acc += m_w[k];
    m_isyn = sat8(m_isyn - floor_div_pow2(m_isyn, TAU_S) + acc);
    res = m_isyn;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    w_we = 1'b0;
    in_valid = 1'b0;
    #1;
    check({tag, "_rst_ir"}, int'(ir), 0);
    check({tag, "_rst_ov"}, int'(out_valid), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check({tag, "_rst_ready"}, int'(in_ready), 1);
    @(negedge clk);
    for (int k = 0; k < W_NUM; k++) m_w[k] = 0;
    m_isyn = 0;
  endtask

  task automatic write_w(input int addr, input int data);
    w_we = 1'b1;
    w_addr = addr[AW-1:0];
    w_data = data[W_WID-1:0];
    cyc();
    w_we = 1'b0;
    m_w[addr] = data;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // One frame: returns ir at the strobe, cycles to strobe, and cycles with in_ready low.
  task automatic run_frame(input string tag, input logic [W_NUM-1:0] sp, input bit scramble,
                           output int ir_val, output int lat, output int ready_low);
    wait_ready(tag);
    in_valid = 1'b1;
    in_spikes = sp;
    cyc();
    in_valid = 1'b0;
    if (scramble) in_spikes = W_NUM'($urandom);
    lat = 0;
    ready_low = in_ready ? 0 : 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
      if (scramble) in_spikes = W_NUM'($urandom);
      if (!in_ready) ready_low++;
    end
    if (!out_valid) check({tag, "_ov_timeout"}, 0, 1);
    ir_val = int'(ir);
    cyc();
    check({tag, "_ov_pulse"}, int'(out_valid), 0);
  endtask

  typedef struct {
    bit              do_reset;
    bit              load;
    int              w0, w1, w2, w3;
    logic [W_NUM-1:0] sp;
    int              exp_ir;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ir_v, lat_v, rl_v, exp_v, n, t1, t2, cyc_n, strobes;
    string tag;

    tbl[0] = '{0, 1,   10,  -20,   30,   40, 4'b1011,   30};
    tbl[1] = '{0, 0,    0,    0,    0,    0, 4'b0000,   15};
    tbl[2] = '{0, 0,    0,    0,    0,    0, 4'b0000,    8};
    tbl[3] = '{0, 0,    0,    0,    0,    0, 4'b0000,    4};
    tbl[4] = '{0, 1,  127,  127,  127,  127, 4'b1111,  127};
    tbl[5] = '{0, 1, -128, -128, -128, -128, 4'b1111, -128};
    tbl[6] = '{1, 1,   -1,    0,    0,    0, 4'b0001,   -1};
    tbl[7] = '{0, 0,    0,    0,    0,    0, 4'b0000,    0};

    @(negedge clk);
    apply_reset("init");

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      if (tbl[i].do_reset) apply_reset(tag);
      if (tbl[i].load) begin
        write_w(0, tbl[i].w0);
        write_w(1, tbl[i].w1);
        write_w(2, tbl[i].w2);
        write_w(3, tbl[i].w3);
      end
      run_frame(tag, tbl[i].sp, 1'b0, ir_v, lat_v, rl_v);
      model_frame(tbl[i].sp, exp_v);
      check({tag, "_ir"}, ir_v, tbl[i].exp_ir);
      check({tag, "_lat"}, lat_v, LAT);
      check({tag, "_ready_low"}, rl_v, LAT);
    end

    // Same-cycle write/read collision and a write ahead of the read index.
    apply_reset("coll");
    write_w(0, 10); write_w(1, -20); write_w(2, 30); write_w(3, 40);
    in_valid = 1'b1;
    in_spikes = 4'b1100;
    cyc();                       // accept edge; now processing k=0
    in_valid = 1'b0;
    cyc();                       // processing k=1
    w_we = 1'b1; w_addr = 2'd3; w_data = 8'd5;
    cyc();                       // processing k=2
    w_addr = 2'd2; w_data = 8'd100;
    cyc();                       // processing k=3
    w_we = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    check("coll_ir", int'(ir), 35);
    check("coll_lat", n + 3, LAT);
    m_w[3] = 5;
    m_isyn = 35;
    m_w[2] = 100;
    run_frame("coll_after", 4'b0100, 1'b0, ir_v, lat_v, rl_v);
    model_frame(4'b0100, exp_v);
    check("coll_after_ir", ir_v, exp_v);

    // Reset in the middle of accumulation.
    wait_ready("midrst");
    in_valid = 1'b1;
    in_spikes = 4'b1111;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();                       // processing k=2
    rst_n = 1'b0;
    #1;
    check("midrst_ir", int'(ir), 0);
    check("midrst_ov", int'(out_valid), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("midrst_ready", int'(in_ready), 1);
    @(negedge clk);
    for (int k = 0; k < W_NUM; k++) m_w[k] = 0;
    m_isyn = 0;
    for (int k = 0; k < W_NUM; k++) write_w(k, 7);
    run_frame("midrst_new", 4'b0001, 1'b0, ir_v, lat_v, rl_v);
    model_frame(4'b0001, exp_v);
    check("midrst_new_ir", ir_v, 7);
    check("midrst_new_lat", lat_v, LAT);

    // Back-to-back frames with in_valid held high: one frame per W_NUM+2 cycles.
    in_valid = 1'b1;
    in_spikes = 4'b0001;
    cyc_n = 0; strobes = 0; t1 = 0; t2 = 0;
    while (strobes < 2 && cyc_n < 40) begin
      cyc();
      cyc_n++;
      if (out_valid) begin
        strobes++;
        model_frame(4'b0001, exp_v);
        check($sformatf("b2b_ir%0d", strobes), int'(ir), exp_v);
        if (strobes == 1) t1 = cyc_n; else t2 = cyc_n;
      end
    end
    in_valid = 1'b0;
    check("b2b_strobes", strobes, 2);
    check("b2b_period", t2 - t1, W_NUM + 2);
    cyc();

    // Randomized frames and weight writes against the model.
    apply_reset("rnd");
    for (int it = 0; it < 40; it++) begin
      int nw, a, d;
      logic [W_NUM-1:0] sp;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) begin
        a = $urandom_range(0, W_NUM - 1);
        d = $urandom_range(0, 255);
        if (d > 127) d -= 256;
        write_w(a, d);
      end
      sp = W_NUM'($urandom);
      tag = $sformatf("rnd%0d", it);
      run_frame(tag, sp, 1'b1, ir_v, lat_v, rl_v);
      model_frame(sp, exp_v);
      check({tag, "_ir"}, ir_v, exp_v);
      check({tag, "_lat"}, lat_v, LAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
